// File: rtl/a0_uart_tx_if.sv
// Bundle between the CPU a0 result and the UART streamer.
// The master drives a0; the slave returns the serial line and queue status.
interface a0_uart_tx_if #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4
);
  logic [DATA_WIDTH-1:0]              a0;
  logic                               tx;
  logic                               busy;
  logic                               overflow;
  logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count;

  modport master (output a0, input tx, busy, overflow, fifo_count);
  modport slave  (input a0, output tx, busy, overflow, fifo_count);
endinterface

// File: rtl/a0_uart_tx.sv
// Queues every change of a0 and streams each queued word as UART 8N1 bytes,
// least-significant byte first.
module a0_uart_tx #(
  parameter int DATA_WIDTH   = 32,
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic         clk,
  input  logic         rst,
  a0_uart_tx_if.slave  bus
);
  localparam int NBYTES = DATA_WIDTH / 8;
  localparam int CW     = $clog2(FIFO_DEPTH + 1);
  localparam int PW     = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = $clog2(CLKS_PER_BIT);
  localparam int BYTE_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e                 state_q;
  logic                   tx_q;
  logic [CNT_W-1:0]       clk_cnt_q;
  logic [2:0]             bit_idx_q;
  logic [BYTE_W-1:0]      byte_idx_q;
  logic [DATA_WIDTH-1:0]  shift_q;
  logic [DATA_WIDTH-1:0]  last_q;
  logic [PW-1:0]          wr_ptr_q;
  logic [PW-1:0]          rd_ptr_q;
  logic [CW-1:0]          count_q;
  logic                   overflow_q;
  logic [DATA_WIDTH-1:0]  mem_q [FIFO_DEPTH];

  logic pop, chg, full, push, wrap;

  always_comb begin
    pop  = (state_q == IDLE) && (count_q != '0);
    chg  = (bus.a0 != last_q);
    full = (count_q == CW'(FIFO_DEPTH));
    // a full FIFO still accepts a push when the same edge pops
    push = chg && (!full || pop);
    wrap = (clk_cnt_q == CNT_W'(CLKS_PER_BIT - 1));
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= bus.a0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      tx_q       <= 1'b1;
      clk_cnt_q  <= '0;
      bit_idx_q  <= '0;
      byte_idx_q <= '0;
      shift_q    <= '0;
      last_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (chg)          last_q     <= bus.a0;
      if (push)         wr_ptr_q   <= wr_ptr_q + 1'b1;
      if (chg && !push) overflow_q <= 1'b1;
      if (pop)          rd_ptr_q   <= rd_ptr_q + 1'b1;
      count_q <= count_q + CW'(push) - CW'(pop);

      if (state_q != IDLE) clk_cnt_q <= wrap ? '0 : clk_cnt_q + 1'b1;

      // the word is shifted right one bit per data bit, so after eight
      // shifts the next byte sits in the low bits
      case (state_q)
        IDLE: begin
          if (pop) begin
            shift_q    <= mem_q[rd_ptr_q];
            byte_idx_q <= '0;
            clk_cnt_q  <= '0;
            tx_q       <= 1'b0;
            state_q    <= START;
          end
        end
        START: begin
          if (wrap) begin
            bit_idx_q <= '0;
            tx_q      <= shift_q[0];
            state_q   <= DATA;
          end
        end
        DATA: begin
          if (wrap) begin
            shift_q <= shift_q >> 1;
            if (bit_idx_q == 3'd7) begin
              tx_q    <= 1'b1;
              state_q <= STOP;
            end else begin
              bit_idx_q <= bit_idx_q + 1'b1;
              tx_q      <= shift_q[1];
            end
          end
        end
        STOP: begin
          if (wrap) begin
            if (byte_idx_q != BYTE_W'(NBYTES - 1)) begin
              byte_idx_q <= byte_idx_q + 1'b1;
              tx_q       <= 1'b0;
              state_q    <= START;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.tx         = tx_q;
  assign bus.busy       = (state_q != IDLE) || (count_q != '0);
  assign bus.overflow   = overflow_q;
  assign bus.fifo_count = count_q;
endmodule

// File: tb/tb_a0_uart_tx.sv
// Bench for a0_uart_tx: a word-level queue model checked every cycle plus
// directed vectors with hand-computed bytes and counts.
module tb_a0_uart_tx;
  localparam int DW       = 32;
  localparam int CPB      = 4;
  localparam int DEPTH    = 4;
  localparam int WORD_CYC = (DW / 8) * 10 * CPB;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  a0_uart_tx_if #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) bus ();
  a0_uart_tx #(.DATA_WIDTH(DW), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int pass_cnt  = 0;
  int total_cnt = 0;
  bit chk_en    = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Model: a queue of words; an active word is described only by the number
  // of cycles elapsed since it was popped.
  logic [DW-1:0] mq[$];
  logic [DW-1:0] m_word, m_last;
  bit            m_active, m_ovf;
  int            m_t;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      m_active = 1'b0; m_ovf = 1'b0; m_t = 0; m_last = '0; m_word = '0;
    end else begin
      bit pop;
      pop = !m_active && (mq.size() > 0);
      if (pop) begin
        m_word = mq.pop_front(); m_active = 1'b1; m_t = 0;
      end else if (m_active) begin
        m_t++;
        if (m_t == WORD_CYC) m_active = 1'b0;
      end
      if (bus.a0 != m_last) begin
        m_last = bus.a0;
        if (mq.size() < DEPTH) mq.push_back(bus.a0);
        else m_ovf = 1'b1;
      end
    end
  end

  function automatic logic model_tx();
    int b, p;
    if (!m_active) return 1'b1;
    b = m_t / (10 * CPB);
    p = (m_t % (10 * CPB)) / CPB;
    if (p == 0) return 1'b0;
    if (p == 9) return 1'b1;
    return m_word[b * 8 + p - 1];
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_tx",    {31'b0, bus.tx},       {31'b0, model_tx()});
      chk("m_busy",  {31'b0, bus.busy},     {31'b0, (m_active || mq.size() != 0)});
      chk("m_ovf",   {31'b0, bus.overflow}, {31'b0, m_ovf});
      chk("m_count", 32'(bus.fifo_count),   32'(mq.size()));
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int maxc);
    int n = 0;
    while (bus.busy && n < maxc) begin step(1); n++; end
    chk("drain_timeout", {31'b0, bus.busy}, 32'd0);
  endtask

  // Called with tx just fallen for the first start bit of a word.
  task automatic decode_word(input logic [7:0] b0, input logic [7:0] b1,
                             input logic [7:0] b2, input logic [7:0] b3);
    logic       rec [WORD_CYC];
    logic [7:0] exp_b [4];
    logic [7:0] got;
    exp_b[0] = b0; exp_b[1] = b1; exp_b[2] = b2; exp_b[3] = b3;
    rec[0] = bus.tx;
    for (int i = 1; i < WORD_CYC; i++) begin step(1); rec[i] = bus.tx; end
    for (int b = 0; b < 4; b++) begin
      for (int k = 0; k < 8; k++) got[k] = rec[b * 40 + (k + 1) * 4 + 2];
      chk("start_bit", {31'b0, rec[b * 40 + 2]}, 32'd0);
      chk("byte",      {24'b0, got},             {24'b0, exp_b[b]});
      chk("stop_bit",  {31'b0, rec[b * 40 + 38]}, 32'd1);
    end
    step(1);
    chk("word_end_busy", {31'b0, bus.busy}, 32'd0);
  endtask

  initial begin
    bus.a0 = '0;
    step(2);
    chk_en = 1'b1;
    chk("rst_tx",    {31'b0, bus.tx},       32'd1);
    chk("rst_busy",  {31'b0, bus.busy},     32'd0);
    chk("rst_count", 32'(bus.fifo_count),   32'd0);
    rst = 1'b0;

    // 1: a0 held at zero sends nothing
    step(200);
    chk("idle_tx",    {31'b0, bus.tx},     32'd1);
    chk("idle_busy",  {31'b0, bus.busy},   32'd0);
    chk("idle_count", 32'(bus.fifo_count), 32'd0);

    // 2: single word, two-edge latency to the falling start bit
    bus.a0 = 32'h1234_5678;
    step(1);
    chk("lat_push_tx",    {31'b0, bus.tx},     32'd1);
    chk("lat_push_count", 32'(bus.fifo_count), 32'd1);
    step(1);
    chk("lat_pop_tx",     {31'b0, bus.tx},     32'd0);
    chk("lat_pop_count",  32'(bus.fifo_count), 32'd0);
    decode_word(8'h78, 8'h56, 8'h34, 8'h12);

    // 3: six changes back to back, the sixth is dropped
    for (int v = 1; v <= 6; v++) begin bus.a0 = 32'(v); step(1); end
    chk("burst_count", 32'(bus.fifo_count), 32'd4);
    chk("burst_ovf",   {31'b0, bus.overflow}, 32'd1);
    wait_idle(1500);
    chk("ovf_sticky",  {31'b0, bus.overflow}, 32'd1);

    // 4: re-applying the same value mid-frame pushes nothing
    bus.a0 = 32'd5;
    step(12);
    chk("same_count0", 32'(bus.fifo_count), 32'd0);
    bus.a0 = 32'd5;
    step(5);
    chk("same_count1", 32'(bus.fifo_count), 32'd0);
    chk("same_busy",   {31'b0, bus.busy},   32'd1);
    wait_idle(400);

    // 5: reset during DATA of byte 2 with words queued
    bus.a0 = 32'hA5A5_0F0F; step(2);
    bus.a0 = 32'h0000_0001; step(1);
    bus.a0 = 32'h0000_0002; step(1);
    chk("pre_rst_count", 32'(bus.fifo_count), 32'd2);
    step(86);
    rst = 1'b1;
    #1;
    chk("mid_rst_tx",    {31'b0, bus.tx},       32'd1);
    chk("mid_rst_count", 32'(bus.fifo_count),   32'd0);
    chk("mid_rst_ovf",   {31'b0, bus.overflow}, 32'd0);
    chk("mid_rst_busy",  {31'b0, bus.busy},     32'd0);
    bus.a0 = 32'hCAFE_F00D;
    step(2);
    rst = 1'b0;
    step(2);
    chk("post_rst_fall", {31'b0, bus.tx}, 32'd0);
    decode_word(8'h0D, 8'hF0, 8'hFE, 8'hCA);

    // 6: full FIFO in IDLE, pop and push on the same edge
    bus.a0 = 32'h1111_1111; step(1);
    bus.a0 = 32'h2222_2222; step(1);
    bus.a0 = 32'h3333_3333; step(1);
    bus.a0 = 32'h4444_4444; step(1);
    bus.a0 = 32'h5555_5555; step(1);
    step(157);
    chk("full_idle_count", 32'(bus.fifo_count), 32'd4);
    chk("full_idle_tx",    {31'b0, bus.tx},     32'd1);
    bus.a0 = 32'h6666_6666;
    step(1);
    chk("pp_count", 32'(bus.fifo_count),   32'd4);
    chk("pp_ovf",   {31'b0, bus.overflow}, 32'd0);
    chk("pp_tx",    {31'b0, bus.tx},       32'd0);
    wait_idle(1000);
    chk("pp_final_ovf", {31'b0, bus.overflow}, 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
